// File: rtl/mult_pkg.sv
// Shared types for the iterative M-extension multiplier.
// Op encoding, FSM states and operand signedness helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mult_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mult_state_e;

  // rs1 is signed for MULH and MULHSU
  function automatic logic is_a_signed(mult_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // rs2 is signed for MULH only
  function automatic logic is_b_signed(mult_op_e op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/mult_iter_step.sv
// One partial-product step of the iterative multiplier.
// Multiplies |a| by a narrow slice of b and aligns it to the step position.
module mult_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SH_W           = 6
) (
  input  logic [WIDTH-1:0]          a_mag,
  input  logic [BITS_PER_CYCLE-1:0] b_bits,
  input  logic [SH_W-1:0]           step,
  output logic [2*WIDTH-1:0]        pp
);

  localparam int SHB = $clog2(2 * WIDTH);

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [SHB-1:0]     shamt;

  // Narrow product, then shift by step * BITS_PER_CYCLE
  always_comb begin
    ext_a = {{WIDTH{1'b0}}, a_mag};
    ext_b = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, b_bits};
    prod  = ext_a * ext_b;
    shamt = SHB'(step) * SHB'(BITS_PER_CYCLE);
    pp    = prod << shamt;
  end

endmodule

// File: rtl/mult_iter.sv
// Iterative integer multiplier for MUL/MULH/MULHSU/MULHU.
// Magnitude multiply over N cycles, then sign fix and half select.
import mult_pkg::*;

module mult_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  mult_state_e state_q, state_d;
  mult_op_e    op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;

  mult_op_e           op_in;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [CNT_W-1:0]   step_idx;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] prod;

  assign op_in    = mult_op_e'(in_op);
  assign step_idx = N_CNT - cnt_q;

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SH_W           (CNT_W)
  ) u_step (
    .a_mag  (a_q),
    .b_bits (b_q[BITS_PER_CYCLE-1:0]),
    .step   (step_idx),
    .pp     (pp)
  );

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Next-state: flush wins over every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (cnt_q == ONE_CNT) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: capture magnitudes, accumulate, negate and select
  always_comb begin
    op_d  = op_q;
    tag_d = tag_q;
    a_d   = a_q;
    b_d   = b_q;
    neg_d = neg_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    sa    = is_a_signed(op_in) & operand_a[WIDTH-1];
    sb    = is_b_signed(op_in) & operand_b[WIDTH-1];
    a_mag = sa ? -operand_a : operand_a;
    b_mag = sb ? -operand_b : operand_b;
    prod  = neg_q ? -acc_q : acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d  = op_in;
          tag_d = in_tag;
          a_d   = a_mag;
          b_d   = b_mag;
          neg_d = sa ^ sb;
          acc_d = '0;
          cnt_d = N_CNT;
        end
      end
      BUSY: begin
        acc_d = acc_q + pp;
        b_d   = b_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q - ONE_CNT;
      end
      FIX: begin
        res_d = (op_q == OP_MUL) ? prod[WIDTH-1:0]
                                 : prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = res_q;
    out_tag   = tag_q;
  end

endmodule

// File: tb/tb_mult_iter.sv
// Self-checking bench for mult_iter.
// Default config plus a BITS_PER_CYCLE=4 instance.
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_valid1;
  logic        flush, out_ready;
  logic [1:0]  in_op;
  logic [31:0] opa, opb;
  logic [4:0]  in_tag;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] result0, result1;
  logic [4:0]  out_tag0, out_tag1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_op(in_op), .operand_a(opa), .operand_b(opb), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .out_tag(out_tag0)
  );

  mult_iter #(.WIDTH(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_op(in_op), .operand_a(opa), .operand_b(opb), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .out_tag(out_tag1)
  );

  typedef struct {
    int          s;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t v[11];

  function automatic logic ir(int s);
    return (s != 0) ? in_ready1 : in_ready0;
  endfunction
  function automatic logic ov(int s);
    return (s != 0) ? out_valid1 : out_valid0;
  endfunction
  function automatic logic [31:0] rs(int s);
    return (s != 0) ? result1 : result0;
  endfunction
  function automatic logic [4:0] tg(int s);
    return (s != 0) ? out_tag1 : out_tag0;
  endfunction

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a,
                                          logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(int s, logic [1:0] op, logic [31:0] a,
                      logic [31:0] b, logic [4:0] t);
    @(negedge clk);
    in_op  = op;
    opa    = a;
    opb    = b;
    in_tag = t;
    if (s != 0) in_valid1 = 1'b1;
    else        in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_ov(int s, bit scr, output int lat);
    lat = 0;
    while (!ov(s) && lat < 200) begin
      if (scr) begin
        in_op  = 2'($urandom);
        opa    = $urandom;
        opb    = $urandom;
        in_tag = 5'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ov(s)) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid timeout: got 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic run(int s, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                     logic [4:0] t, bit scr, output logic [31:0] r,
                     output logic [4:0] ot, output int lat);
    send(s, op, a, b, t);
    wait_ov(s, scr, lat);
    r  = rs(s);
    ot = tg(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  ot;
    int          lat;
    bit          seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; opa = '0; opb = '0; in_tag = '0;

    v[0]  = '{0, 2'b00, 32'd7,        32'd6,        32'h0000_002A, 33};
    v[1]  = '{0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    v[2]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    v[3]  = '{0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    v[4]  = '{0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    v[5]  = '{0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    v[6]  = '{0, 2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 33};
    v[7]  = '{0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    v[8]  = '{0, 2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33};
    v[9]  = '{1, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 9};
    v[10] = '{1, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 9};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready0), 32'd1);
    chk("reset out_valid", 32'(out_valid0), 32'd0);
    chk("reset result", result0, 32'd0);
    chk("reset out_tag", 32'(out_tag0), 32'd0);
    chk("reset in_ready bpc4", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, 5'(i + 1), 1'b0, r, ot, lat);
      chk($sformatf("vec%0d result", i), r, v[i].exp);
      chk($sformatf("vec%0d out_tag", i), 32'(ot), 32'(i + 1));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(v[i].lat));
    end

    // backpressure: hold out_ready low for 10 cycles
    out_ready = 1'b0;
    send(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    wait_ov(0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp result", result0, 32'hFFFF_FFFE);
      chk("bp out_tag", 32'(out_tag0), 32'd9);
      chk("bp in_ready", 32'(in_ready0), 32'd0);
      chk("bp out_valid", 32'(out_valid0), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", 32'(in_ready0), 32'd1);
    chk("bp release out_valid", 32'(out_valid0), 32'd0);

    // input hold: inputs scrambled every cycle after accept
    run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'h15, 1'b1, r, ot, lat);
    chk("hold result", r, 32'h8000_0000);
    chk("hold out_tag", 32'(ot), 32'h15);
    run(1, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'h0A, 1'b1, r, ot, lat);
    chk("hold bpc4 result", r, 32'hFFFF_FFFF);
    chk("hold bpc4 out_tag", 32'(ot), 32'h0A);

    // flush in BUSY cycle 5
    send(0, 2'b00, 32'd7, 32'd6, 5'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy in_ready", 32'(in_ready0), 32'd1);
    chk("flush busy out_valid", 32'(out_valid0), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid0) seen = 1'b1;
    end
    chk("flush busy no result", 32'(seen), 32'd0);

    // flush with in_valid in IDLE: no accept
    @(negedge clk);
    flush = 1'b1;
    in_valid0 = 1'b1;
    in_op = 2'b00; opa = 32'd5; opb = 32'd5; in_tag = 5'd7;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid0 = 1'b0;
    chk("flush idle in_ready", 32'(in_ready0), 32'd1);
    run(0, 2'b00, 32'd12, 32'd11, 5'd4, 1'b0, r, ot, lat);
    chk("post flush result", r, 32'd132);
    chk("post flush out_tag", 32'(ot), 32'd4);
    chk("post flush latency", 32'(lat), 32'd33);

    // flush in DONE discards result even with out_ready high
    out_ready = 1'b0;
    send(0, 2'b00, 32'd3, 32'd3, 5'd2);
    wait_ov(0, 1'b0, lat);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush done out_valid", 32'(out_valid0), 32'd0);
    chk("flush done in_ready", 32'(in_ready0), 32'd1);

    // async reset mid-BUSY
    send(0, 2'b00, 32'd7, 32'd6, 5'd3);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst in_ready", 32'(in_ready0), 32'd1);
    chk("async rst out_valid", 32'(out_valid0), 32'd0);
    chk("async rst result", result0, 32'd0);
    chk("async rst out_tag", 32'(out_tag0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid0) seen = 1'b1;
    end
    chk("async rst no result", 32'(seen), 32'd0);

    // randomised runs against the reference model
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      run(1, rop, ra, rb, 5'(i), 1'b0, r, ot, lat);
      chk($sformatf("rand4 op%0d 0x%0h*0x%0h", rop, ra, rb), r,
          ref_mul(rop, ra, rb));
      if (i % 100 == 0) chk("rand4 latency", 32'(lat), 32'd9);
    end
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      run(0, rop, ra, rb, 5'(i), 1'b0, r, ot, lat);
      chk($sformatf("rand1 op%0d 0x%0h*0x%0h", rop, ra, rb), r,
          ref_mul(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
# mult_iter

Parametrised iterative integer multiplier for the M-extension datapath. Computes a 2·WIDTH-bit product over several cycles at BITS_PER_CYCLE multiplier bits per cycle and returns the RISC-V-selected half for MUL, MULH, MULHSU or MULHU. Sits between the decode/issue stage and writeback, with valid/ready handshakes on both sides and a tag carried through for the destination register.

## Interface

Parameters:

- WIDTH, 32, operand width; even, ≥ 8.
- BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; must divide WIDTH (1, 2, 4, 8).
- TAG_W, 5, width of the pass-through tag.

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  2  mult_op_e: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand_a  in  WIDTH  rs1 value.
- operand_b  in  WIDTH  rs2 value.
- in_tag  in  TAG_W  opaque tag.
- flush  in  1  synchronous kill of any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  selected product half.
- out_tag  out  TAG_W  tag captured with the request.

## Operation

- FSM states:
  - IDLE: in_ready = 1.
  - BUSY: iterating.
  - FIX: sign correction and half select.
  - DONE: out_valid = 1.
- Signedness:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - MUL low half is identical for all signedness, so it is treated as unsigned.
- Accept (IDLE, in_valid=1):
  - Register op and tag.
  - Register |a| and |b| per signedness.
  - neg = sign_a XOR sign_b.
  - acc = 0, count = N = WIDTH/BITS_PER_CYCLE.
  - Go to BUSY.
- BUSY step:
  - acc += |a| · (low BITS_PER_CYCLE bits of the b shift register), shifted by the step position.
  - b shifts right by BITS_PER_CYCLE; count decrements.
  - When count reaches 0, go to FIX.
- FIX:
  - Product p = neg ? −acc : acc, taken mod 2^(2·WIDTH).
  - result = p[WIDTH-1:0] for MUL, otherwise p[2·WIDTH-1:WIDTH].
  - Go to DONE.
- DONE:
  - Hold result and out_tag stable until out_ready = 1, then go to IDLE.
- Operand magnitude edge case: the most negative value (e.g. 0x80000000) has magnitude 2^(WIDTH-1), which fits unsigned WIDTH bits. No special case.
- flush: forces IDLE on the next edge from any state and drops out_valid.
  - flush overrides acceptance in the same cycle: nothing is accepted.
  - flush in DONE discards the result even if out_ready = 1.
- Inputs are sampled only on the accept edge. Later changes on operand_a, operand_b, in_op or in_tag are ignored.
- Outputs on reset:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result = 0, out_tag = 0.
  - Internal accumulator and counters are cleared.
- Reset asserted mid-operation aborts the operation immediately and asynchronously. No result is produced.

## Timing

- Accept on edge 0 → BUSY on edges 1..N → FIX on edge N+1 → out_valid high from edge N+1.
  - Latency is N+1 cycles from acceptance to result.
  - Example: 33 cycles for WIDTH=32, BITS_PER_CYCLE=1; 9 cycles for BITS_PER_CYCLE=4.
- Latency is fixed and independent of operand values.
- in_ready is high only in IDLE, so there is no overlap between operations.
- Minimum spacing between accepts: N+3 cycles with out_ready held at 1 (accept, N BUSY, FIX, DONE, then IDLE).
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to either.

## Structure

- Package mult_pkg contains:
  - mult_op_e (2-bit enum).
  - mult_state_e (IDLE, BUSY, FIX, DONE).
  - Helper functions is_a_signed(op) and is_b_signed(op).
- Sub-module mult_step is combinational, parametrised by WIDTH and BITS_PER_CYCLE. It takes |a| and a BITS_PER_CYCLE-bit slice of b and returns the shifted partial product.
- mult_iter instantiates one mult_step plus the FSM, the operand, accumulator and count registers, and the FIX negate/select logic.

## Test plan

- Default parameters (WIDTH=32, BITS_PER_CYCLE=1):
  - MUL 7×6 → result 0x0000002A, out_valid 33 cycles after accept, out_tag echoed.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid → result and out_tag stable, in_ready = 0 throughout.
  - Raise out_ready → IDLE next edge, in_ready = 1.
- Input hold: change operand_a, operand_b, in_op and in_tag every cycle after accept → result matches the values sampled on the accept edge.
- flush:
  - Assert flush in BUSY cycle 5 → IDLE next edge, out_valid never rises.
  - flush with in_valid=1 in IDLE → no accept.
  - Next request completes correctly.
- Async reset:
  - Pulse rst mid-BUSY (between clock edges) → in_ready = 1 and out_valid = 0 immediately; result and out_tag read 0.
- BITS_PER_CYCLE=4, WIDTH=32:
  - MULH 0xFFFFFFFE(−2)×0x00000003 → 0xFFFFFFFF.
  - MUL 0xFFFFFFFE×0x00000003 → 0xFFFFFFFA.
  - Latency 9 cycles.
  - Randomised run of 1000 ops matches a reference model.
